mac_operand_splitter: RTL and testbench
=======================================

// Module: mac_operand_splitter
// PURPOSE
//   Slices wide unsigned multiply operands into MAC_MIN_WIDTH-bit sub-operand pairs for the four sub-MAC lanes.
//   Schedules every cross product over 1/2/4 beats per cfg; each lane gets a weight tag for downstream shift-and-sum.
//   Sits upstream of the sub-MACs and is the input-side counterpart of mac_combiner (which merges the partials).
//   Valid/ready on both sides; registered outputs.
// PARAMETERS
//   MIN_W  8  sub-operand slice width (= MAC_MIN_WIDTH); operand width is 4*MIN_W
// PORTS
//   clk        in   1        clock
//   rst        in   1        synchronous reset, active-high
//   en         in   1        0: freeze state and outputs; forces in_ready=0
//   cfg        in   2        2'b00 MAC_SINGLE, 2'b01 MAC_DUAL, 2'b10 MAC_QUAD, 2'b11 treated as SINGLE
//   in_a       in   4*MIN_W  operand A (DUAL: op0=[2*MIN_W-1:0], op1=upper half)
//   in_b       in   4*MIN_W  operand B, packed as in_a
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        splitter can accept (combinational)
//   lane_a     out  4*MIN_W  lane L A-slice at [L*MIN_W +: MIN_W]
//   lane_b     out  4*MIN_W  lane L B-slice, same packing
//   lane_wt    out  12       lane L weight index at [3L +: 3], 0..6 (product shift = wt*MIN_W)
//   beat_idx   out  2        beat number within current transaction
//   out_valid  out  1        lane outputs valid
//   out_last   out  1        final beat of transaction
//   out_ready  in   1        downstream accepts current beat
// BEHAVIOUR
//   Reset: out_valid=0, out_last=0, lane_a/lane_b/lane_wt=0, beat_idx=0, state=IDLE. Reset overrides en.
//   Format rule: A[k] = in_a[k*MIN_W +: MIN_W], same for B. Unsigned only.
//   FSM: IDLE --(in_valid&in_ready)--> ISSUE; ISSUE advances beat on out_valid&out_ready.
//     On last beat handshake: new accept -> stay ISSUE at beat 0; else -> IDLE.
//   in_ready = en & (IDLE | (out_valid & out_last & out_ready)); no bubble between transactions.
//   Accept latches in_a, in_b, cfg; input changes after accept are ignored. Beat 0 appears the next cycle (latency 1).
//   Beat schedule, beat k, lane L:
//     SINGLE (1 beat):  a=A[L], b=B[L], wt=0.
//     DUAL (2 beats, k=0..1): lanes 0,1 use op0: a=A[k], b=B[L], wt=k+L.
//       Lanes 2,3 use op1: a=A[2+k], b=B[L], wt=k+(L-2).
//     QUAD (4 beats, k=0..3): a=A[k], b=B[L], wt=k+L.
//   out_last=1 on beat (N-1); beat_idx=k.
//   Backpressure: while out_valid & !out_ready, all outputs hold stable; beat does not advance.
//   en=0: no accept and no beat advance; outputs hold. Handshake is not consumed even if out_ready=1.
//   Sum over all beats/lanes of (a*b)<<(wt*MIN_W) equals the full product per cfg.
//     DUAL is summed per operand half.
//   Reset mid-transaction: aborts; next cycle out_valid=0, in_ready=en.
// TESTING
//   SINGLE A=0x04030201 B=0x08070605 -> 1 beat.
//     lane_a=0x04030201, lane_b=0x08070605, all wt=0, out_last=1, beat_idx=0.
//   QUAD A=0x11223344 B=0x55667788 -> 4 beats.
//     beat0: a lanes=44, b=88,77,66,55, wt=0,1,2,3.
//     beat3: a=11, wt=3,4,5,6, out_last=1.
//     Model sum of products = 0x11223344*0x55667788.
//   DUAL A=0x12345678 B=0x9ABCDEF0 -> 2 beats.
//     beat0 lanes: (78,F0,0),(78,DE,1),(34,BC,0),(34,9A,1).
//     beat1 lanes: (56,F0,1),(56,DE,2),(12,BC,1),(12,9A,2). out_last on beat1.
//   QUAD, out_ready=0 for 3 cycles at beat1 -> outputs and beat_idx frozen at 1.
//     Resumes to beat2 after out_ready=1.
//   Back-to-back: SINGLE then QUAD; in_valid held.
//     QUAD accepted in the SINGLE last-beat handshake cycle; QUAD beat0 valid next cycle, no idle cycle.
//   rst=1 during QUAD beat2 -> next cycle out_valid=0, out_last=0, in_ready=1.
//     A new SINGLE then completes normally.

Source files
------------

// File: rtl/mac_operand_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_splitter
//  Description : Slices wide unsigned multiply operands into MIN_W-bit
//                sub-operand pairs for four sub-MAC lanes and schedules every
//                cross product over 1 (SINGLE), 2 (DUAL) or 4 (QUAD) beats.
//                Each lane carries a weight tag; the downstream combiner
//                shifts each partial product left by wt*MIN_W and sums.
//  Ports       : clk, rst (sync, active-high), en (freeze when 0)
//                cfg[1:0]   00 SINGLE, 01 DUAL, 10 QUAD, 11 -> SINGLE
//                in_a/in_b  operands, in_valid/in_ready handshake
//                lane_a/lane_b  lane L slice at [L*MIN_W +: MIN_W]
//                lane_wt    lane L weight at [3L +: 3]
//                beat_idx, out_valid, out_last, out_ready  beat handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_splitter #(
  parameter int MIN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         cfg,
  input  logic [4*MIN_W-1:0] in_a,
  input  logic [4*MIN_W-1:0] in_b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*MIN_W-1:0] lane_a,
  output logic [4*MIN_W-1:0] lane_b,
  output logic [11:0]        lane_wt,
  output logic [1:0]         beat_idx,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  localparam logic [1:0] c_MODE_SINGLE = 2'b00;
  localparam logic [1:0] c_MODE_DUAL   = 2'b01;
  localparam logic [1:0] c_MODE_QUAD   = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4*MIN_W-1:0] r_a;
  logic [4*MIN_W-1:0] r_b;
  logic [1:0]         r_mode;
  logic [1:0]         r_beat;
  logic [4*MIN_W-1:0] r_lane_a;
  logic [4*MIN_W-1:0] r_lane_b;
  logic [11:0]        r_lane_wt;
  logic               r_out_valid;
  logic               r_out_last;

  logic               w_accept;
  logic               w_out_hs;
  logic [1:0]         w_in_mode;
  logic [4*MIN_W-1:0] w_src_a;
  logic [4*MIN_W-1:0] w_src_b;
  logic [1:0]         w_src_mode;
  logic [1:0]         w_src_beat;
  logic [1:0]         w_last_beat;
  logic               w_nxt_last;
  logic [4*MIN_W-1:0] w_nxt_lane_a;
  logic [4*MIN_W-1:0] w_nxt_lane_b;
  logic [11:0]        w_nxt_lane_wt;

  // A new transaction may be taken while idle, or in the very cycle the
  // final beat of the current one is consumed, so there is no bubble.
  assign in_ready  = en & ((r_state == ST_IDLE) | (r_out_valid & r_out_last & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = en & r_out_valid & out_ready;
  assign w_in_mode = (cfg == 2'b11) ? c_MODE_SINGLE : cfg;

  // The next beat is built either from the operands being accepted right
  // now (beat 0) or from the latched operands (following beat).
  assign w_src_a    = w_accept ? in_a      : r_a;
  assign w_src_b    = w_accept ? in_b      : r_b;
  assign w_src_mode = w_accept ? w_in_mode : r_mode;
  assign w_src_beat = w_accept ? 2'd0      : r_beat + 2'd1;

  always_comb begin
    w_last_beat = 2'd0;
    case (w_src_mode)
      c_MODE_DUAL: w_last_beat = 2'd1;
      c_MODE_QUAD: w_last_beat = 2'd3;
      default:     w_last_beat = 2'd0;
    endcase
  end

  assign w_nxt_last = (w_src_beat == w_last_beat);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    // In DUAL mode lanes 0/1 work on the low operand half and lanes 2/3 on
    // the high half, so each pair sees its own A-slice base and weight origin.
    localparam int c_DUAL_BASE = (l < 2) ? 0 : 2;
    localparam int c_DUAL_OFS  = (l < 2) ? l : l - 2;

    logic [1:0] w_a_idx;
    logic [2:0] w_wt;

    always_comb begin
      w_a_idx = 2'(l);
      w_wt    = 3'd0;
      case (w_src_mode)
        c_MODE_DUAL: begin
          w_a_idx = 2'(c_DUAL_BASE) + w_src_beat;
          w_wt    = {1'b0, w_src_beat} + 3'(c_DUAL_OFS);
        end
        c_MODE_QUAD: begin
          w_a_idx = w_src_beat;
          w_wt    = {1'b0, w_src_beat} + 3'(l);
        end
        default: begin
          w_a_idx = 2'(l);
          w_wt    = 3'd0;
        end
      endcase
    end

    assign w_nxt_lane_a[l*MIN_W +: MIN_W] = w_src_a[int'(w_a_idx)*MIN_W +: MIN_W];
    assign w_nxt_lane_b[l*MIN_W +: MIN_W] = w_src_b[l*MIN_W +: MIN_W];
    assign w_nxt_lane_wt[3*l +: 3]        = w_wt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_out_hs && r_out_last && !w_accept) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= c_MODE_SINGLE;
      r_beat      <= 2'd0;
      r_lane_a    <= '0;
      r_lane_b    <= '0;
      r_lane_wt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_mode <= w_in_mode;
      end
      if (w_accept || (w_out_hs && !r_out_last)) begin
        r_beat      <= w_src_beat;
        r_lane_a    <= w_nxt_lane_a;
        r_lane_b    <= w_nxt_lane_b;
        r_lane_wt   <= w_nxt_lane_wt;
        r_out_valid <= 1'b1;
        r_out_last  <= w_nxt_last;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign lane_a    = r_lane_a;
  assign lane_b    = r_lane_b;
  assign lane_wt   = r_lane_wt;
  assign beat_idx  = r_beat;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_operand_splitter
//  Description : Self-checking bench for mac_operand_splitter. Directed
//                scenarios plus randomized transactions against a reference
//                model of the beat schedule and of the full products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_operand_splitter;

  localparam int MIN_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  cfg;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lane_a;
  logic [31:0] lane_b;
  logic [11:0] lane_wt;
  logic [1:0]  beat_idx;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mac_operand_splitter #(.MIN_W(MIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane_a    (lane_a),
    .lane_b    (lane_b),
    .lane_wt   (lane_wt),
    .beat_idx  (beat_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: byte k of A/B is A[k]/B[k]. Lane L always gets B[L].
  // SINGLE pairs A[L] with B[L]; QUAD walks A[k] across all B slices;
  // DUAL treats each 16-bit half as its own QUAD-like 2x2 product.
  function automatic int n_beats(input logic [1:0] c);
    if (c == 2'b01) return 2;
    if (c == 2'b10) return 4;
    return 1;
  endfunction

  function automatic void model_beat(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] c, input int k,
                                     output logic [31:0] la, output logic [31:0] lb,
                                     output logic [11:0] wt);
    la = '0; lb = '0; wt = '0;
    for (int L = 0; L < 4; L++) begin
      lb[L*8 +: 8] = b[L*8 +: 8];
      if (c == 2'b01) begin
        la[L*8 +: 8]  = a[(2*(L/2) + k)*8 +: 8];
        wt[3*L +: 3]  = 3'(k + (L % 2));
      end else if (c == 2'b10) begin
        la[L*8 +: 8]  = a[k*8 +: 8];
        wt[3*L +: 3]  = 3'(k + L);
      end else begin
        la[L*8 +: 8]  = a[L*8 +: 8];
        wt[3*L +: 3]  = 3'd0;
      end
    end
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    int t;
    @(negedge clk);
    in_a = a; in_b = b; cfg = c; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the latched copies must be used from here on.
    in_a = $urandom; in_b = $urandom; cfg = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_valid();
    int t;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL wait_valid_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; cfg = 2'b00; in_a = '0; in_b = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, lane_a, lane_b, lane_wt, beat_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%0b l=%0b a=%h b=%h wt=%h beat=%0d required all 0",
               out_valid, out_last, lane_a, lane_b, lane_wt, beat_idx);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    send(32'h04030201, 32'h08070605, 2'b00);
    wait_valid();
    n_checks++;
    if ({lane_a, lane_b, lane_wt, out_last, beat_idx} !== {32'h04030201, 32'h08070605, 12'h000, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL single_beat: a=%h b=%h wt=%h last=%0b beat=%0d required 04030201 08070605 000 1 0",
               lane_a, lane_b, lane_wt, out_last, beat_idx);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_quad();
    logic [31:0] ea, eb;
    logic [11:0] ew;
    logic [63:0] sum;
    sum = '0;
    send(32'h11223344, 32'h55667788, 2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_valid();
      model_beat(32'h11223344, 32'h55667788, 2'b10, k, ea, eb, ew);
      n_checks++;
      if ({lane_a, lane_b, lane_wt, beat_idx, out_last} !== {ea, eb, ew, 2'(k), 1'(k == 3)}) begin
        n_fail++;
        $display("FAIL quad_beat%0d: a=%h b=%h wt=%h beat=%0d last=%0b required %h %h %h %0d %0b",
                 k, lane_a, lane_b, lane_wt, beat_idx, out_last, ea, eb, ew, k, k == 3);
      end
      if (k == 0) begin
        n_checks++;
        if ({lane_a, lane_b, lane_wt} !== {32'h44444444, 32'h55667788, 12'h688}) begin
          n_fail++;
          $display("FAIL quad_beat0_const: a=%h b=%h wt=%h required 44444444 55667788 688", lane_a, lane_b, lane_wt);
        end
      end
      if (k == 3) begin
        n_checks++;
        if ({lane_a, lane_wt, out_last} !== {32'h11111111, 12'hD63, 1'b1}) begin
          n_fail++;
          $display("FAIL quad_beat3_const: a=%h wt=%h last=%0b required 11111111 d63 1", lane_a, lane_wt, out_last);
        end
      end
      for (int L = 0; L < 4; L++)
        sum += (64'(lane_a[L*8 +: 8]) * 64'(lane_b[L*8 +: 8])) << (8 * int'(lane_wt[3*L +: 3]));
    end
    n_checks++;
    if (sum !== 64'h11223344 * 64'h55667788) begin
      n_fail++;
      $display("FAIL quad_product: got %h required %h", sum, 64'h11223344 * 64'h55667788);
    end
  endtask

  task automatic test_dual();
    send(32'h12345678, 32'h9ABCDEF0, 2'b01);
    wait_valid();
    n_checks++;
    if ({lane_a, lane_b, lane_wt, beat_idx, out_last} !== {32'h34347878, 32'h9ABCDEF0, 12'h208, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL dual_beat0: a=%h b=%h wt=%h beat=%0d last=%0b required 34347878 9abcdef0 208 0 0",
               lane_a, lane_b, lane_wt, beat_idx, out_last);
    end
    wait_valid();
    n_checks++;
    if ({lane_a, lane_b, lane_wt, beat_idx, out_last} !== {32'h12125656, 32'h9ABCDEF0, 12'h451, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL dual_beat1: a=%h b=%h wt=%h beat=%0d last=%0b required 12125656 9abcdef0 451 1 1",
               lane_a, lane_b, lane_wt, beat_idx, out_last);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ha, hb;
    logic [11:0] hw;
    send(32'hA1B2C3D4, 32'h0F1E2D3C, 2'b10);
    wait_valid();
    @(negedge clk);
    out_ready = 1'b0;
    ha = lane_a; hb = lane_b; hw = lane_wt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, beat_idx, lane_a, lane_b, lane_wt} !== {1'b1, 2'd1, ha, hb, hw}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%0b beat=%0d a=%h wt=%h required 1 1 %h %h", i, out_valid, beat_idx, lane_a, lane_wt, ha, hw);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, beat_idx, lane_a} !== {1'b1, 2'd2, 32'hB2B2B2B2}) begin
      n_fail++;
      $display("FAIL bp_resume: v=%0b beat=%0d a=%h required 1 2 b2b2b2b2", out_valid, beat_idx, lane_a);
    end
    wait_valid();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_a = 32'hDEADBEEF; in_b = 32'h01020304; cfg = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, lane_a} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL b2b_single: v=%0b l=%0b a=%h required 1 1 deadbeef", out_valid, out_last, lane_a);
    end
    in_a = 32'hCAFEF00D; in_b = 32'h13579BDF; cfg = 2'b10;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_on_last: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, beat_idx, out_last, lane_a, lane_wt} !== {1'b1, 2'd0, 1'b0, 32'h0D0D0D0D, 12'h688}) begin
      n_fail++;
      $display("FAIL b2b_quad_beat0: v=%0b beat=%0d l=%0b a=%h wt=%h required 1 0 0 0d0d0d0d 688",
               out_valid, beat_idx, out_last, lane_a, lane_wt);
    end
    for (int k = 1; k < 4; k++) wait_valid();
  endtask

  task automatic test_enable();
    send(32'h89ABCDEF, 32'h76543210, 2'b10);
    wait_valid();
    en = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL en_in_ready: got %0b required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, beat_idx} !== {1'b1, 2'd0}) begin
        n_fail++;
        $display("FAIL en_freeze%0d: v=%0b beat=%0d required 1 0", i, out_valid, beat_idx);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (beat_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL en_resume: beat=%0d required 1", beat_idx);
    end
    for (int k = 2; k < 4; k++) wait_valid();
    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; cfg = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL en_no_accept%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
    in_valid = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ea, eb, a, b;
    logic [11:0] ew;
    send(32'h0BADF00D, 32'h600DCAFE, 2'b10);
    for (int k = 0; k < 3; k++) wait_valid();
    n_checks++;
    if (beat_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_beat: beat=%0d required 2", beat_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_last, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_abort: v=%0b l=%0b rdy=%0b required 0 0 1", out_valid, out_last, in_ready);
    end
    rst = 1'b0;
    a = $urandom; b = $urandom;
    send(a, b, 2'b00);
    wait_valid();
    model_beat(a, b, 2'b00, 0, ea, eb, ew);
    n_checks++;
    if ({lane_a, lane_b, lane_wt, out_last, beat_idx} !== {ea, eb, ew, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL rstmid_single: a=%h b=%h wt=%h l=%0b required %h %h %h 1", lane_a, lane_b, lane_wt, out_last, ea, eb, ew);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ea, eb, ha, hb;
    logic [11:0] ew, hw;
    logic [1:0]  c, hbeat;
    logic [63:0] sum_q, sum_lo, sum_hi;
    logic        hold;
    int          nb, k, t, m;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; b = $urandom; c = 2'($urandom_range(0, 3));
      nb = n_beats(c);
      m = (c == 2'b11) ? 0 : int'(c);
      sum_q = '0; sum_lo = '0; sum_hi = '0;
      send(a, b, c);
      k = 0; t = 0; hold = 1'b0;
      ha = '0; hb = '0; hw = '0; hbeat = '0;
      while (k < nb && t < 500) begin
        @(negedge clk);
        t++;
        if (hold) begin
          n_checks++;
          if ({lane_a, lane_b, lane_wt, beat_idx, out_valid} !== {ha, hb, hw, hbeat, 1'b1}) begin
            n_fail++;
            $display("FAIL rnd_hold: a=%h wt=%h beat=%0d required %h %h %0d", lane_a, lane_wt, beat_idx, ha, hw, hbeat);
          end
        end
        out_ready = ($urandom_range(0, 3) != 0);
        hold = out_valid & ~out_ready;
        ha = lane_a; hb = lane_b; hw = lane_wt; hbeat = beat_idx;
        if (out_valid && out_ready) begin
          model_beat(a, b, c, k, ea, eb, ew);
          n_checks++;
          if ({lane_a, lane_b, lane_wt, beat_idx, out_last} !== {ea, eb, ew, 2'(k), 1'(k == nb - 1)}) begin
            n_fail++;
            $display("FAIL rnd_beat: cfg=%0d k=%0d a=%h b=%h wt=%h beat=%0d l=%0b required %h %h %h %0d %0b",
                     c, k, lane_a, lane_b, lane_wt, beat_idx, out_last, ea, eb, ew, k, k == nb - 1);
          end
          for (int L = 0; L < 4; L++) begin
            if (L < 2)
              sum_lo += (64'(lane_a[L*8 +: 8]) * 64'(lane_b[L*8 +: 8])) << (8 * int'(lane_wt[3*L +: 3]));
            else
              sum_hi += (64'(lane_a[L*8 +: 8]) * 64'(lane_b[L*8 +: 8])) << (8 * int'(lane_wt[3*L +: 3]));
            sum_q += (64'(lane_a[L*8 +: 8]) * 64'(lane_b[L*8 +: 8])) << (8 * int'(lane_wt[3*L +: 3]));
          end
          k++;
        end
      end
      out_ready = 1'b1;
      n_checks++;
      if (k != nb) begin
        n_fail++;
        $display("FAIL rnd_timeout: beats=%0d required %0d", k, nb);
      end
      if (m == 2) begin
        n_checks++;
        if (sum_q !== 64'(a) * 64'(b)) begin
          n_fail++;
          $display("FAIL rnd_quad_product: got %h required %h", sum_q, 64'(a) * 64'(b));
        end
      end else if (m == 1) begin
        n_checks++;
        if ({sum_lo, sum_hi} !== {64'(a[15:0]) * 64'(b[15:0]), 64'(a[31:16]) * 64'(b[31:16])}) begin
          n_fail++;
          $display("FAIL rnd_dual_product: lo=%h hi=%h required %h %h", sum_lo, sum_hi,
                   64'(a[15:0]) * 64'(b[15:0]), 64'(a[31:16]) * 64'(b[31:16]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_quad();
    test_dual();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
